// File: rtl/hilo_div_unit_pkg.sv
// Shared encodings for the HI/LO divider: FSM states, ready/start levels and reset/zero defines.
`ifndef RstEnable
`define RstEnable 1'b1
`endif
`ifndef ZeroWord
`define ZeroWord 32'h00000000
`endif

package hilo_div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/hilo_div_unit_div_step.sv
// One radix-2 restoring divide iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvs_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic        [WIDTH:0] shifted;
    logic signed [WIDTH:0] trial;

    assign shifted = {rem_i, bit_i};
    // rem_i < dvs_i always holds, so the sign bit of the (WIDTH+1)-bit difference is exact.
    assign trial   = $signed(shifted - {1'b0, dvs_i});
    assign qbit_o  = ~trial[WIDTH];
    assign rem_o   = qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/hilo_div_unit.sv
// Multi-cycle DIV/DIVU unit producing {HI, LO} = {remainder, quotient}; one restoring step per cycle.
// Optional macro HILO_DIV_EARLY_OUT_EN finishes at once when |dividend| < |divisor|.
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvs_q, rem_q;
    logic               neg_dvd_q, neg_quo_q;
    logic [2*WIDTH-1:0] res_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [WIDTH-1:0]   step_rem, quo_raw, quo_fix, rem_fix;
    logic               step_q, accept, last_iter, early_out;

    function automatic logic [WIDTH-1:0] abs_op(input logic signed [WIDTH-1:0] v, input logic is_signed);
        logic [WIDTH-1:0] u;
        u = v;
        if (is_signed && v < 0)
            u = -u;
        return u;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign op1_abs   = abs_op(opdata1_i, signed_div_i);
    assign op2_abs   = abs_op(opdata2_i, signed_div_i);
    assign accept    = (state_q == DivFree) && (start_i == DivStart) && !annul_i;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef HILO_DIV_EARLY_OUT_EN
    assign early_out = (opdata2_i != '0) && (op1_abs < op2_abs);
`else
    assign early_out = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i  (rem_q),
        .dvs_i  (dvs_q),
        .bit_i  (dvd_q[WIDTH-1]),
        .rem_o  (step_rem),
        .qbit_o (step_q)
    );

    // The dividend register doubles as the quotient shift register.
    assign quo_raw = {dvd_q[WIDTH-2:0], step_q};
    assign quo_fix = neg_if(quo_raw, neg_quo_q);
    assign rem_fix = neg_if(step_rem, neg_dvd_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stallreq_o = 1'b0;
        case (state_q)
            DivFree: begin
                if (accept) begin
                    stallreq_o = 1'b1;
                    cnt_d      = '0;
                    if (opdata2_i == '0)
                        state_d = DivByZero;
                    else if (early_out)
                        state_d = DivEnd;
                    else
                        state_d = DivOn;
                end
            end
            DivByZero: begin
                stallreq_o = 1'b1;
                state_d    = DivEnd;
            end
            DivOn: begin
                stallreq_o = 1'b1;
                cnt_d      = cnt_q + CNT_W'(1);
                if (last_iter)
                    state_d = DivEnd;
            end
            DivEnd: begin
                if (start_i == DivStop)
                    state_d = DivFree;
            end
            default: state_d = DivFree;
        endcase
        if (annul_i && state_q != DivFree)
            state_d = DivFree;
    end

    // Ready only once END has been held for a full cycle, so it never coincides with a departure.
    assign ready_d = (state_q == DivEnd && state_d == DivEnd) ? DivResultReady : DivResultNotReady;

    always_ff @(posedge clk) begin
        if (resetn == `RstEnable) begin
            state_q  <= DivFree;
            cnt_q    <= '0;
            ready_q  <= DivResultNotReady;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            result_q <= ready_d ? res_q : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            dvd_q     <= op1_abs;
            dvs_q     <= op2_abs;
            rem_q     <= '0;
            neg_dvd_q <= signed_div_i & opdata1_i[WIDTH-1];
            neg_quo_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            if (early_out)
                res_q <= {opdata1_i, {WIDTH{1'b0}}};
        end else if (state_q == DivOn) begin
            rem_q <= step_rem;
            dvd_q <= quo_raw;
            if (last_iter)
                res_q <= {rem_fix, quo_fix};
        end else if (state_q == DivByZero) begin
            res_q <= '0;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: vector table, scoreboard queue and flush/reset/hold sequences.
module tb_hilo_div_unit;

    localparam int WIDTH = 32;
`ifdef HILO_DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_chk = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last_exp;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl[11];

    hilo_div_unit #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sbv;
        if (b == 0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa  = a;
        sbv = b;
        return {32'(sa % sbv), 32'(sa / sbv)};
    endfunction

    function automatic int exp_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] aa, ab;
        aa = (sgn && a[31]) ? -a : a;
        ab = (sgn && b[31]) ? -b : b;
        if (b == 0) return 2;
        if (EARLY && aa < ab) return 1;
        return WIDTH + 1;
    endfunction

    task automatic launch(input bit sgn, input logic [31:0] a, input logic [31:0] b, input string name);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        sb_q.push_back(model(sgn, a, b));
        #1;
        check({name, "_stall_accept"}, 64'(stallreq_o), 64'd1);
    endtask

    task automatic await_result(input int lat, input string name);
        int k;
        bit stall_bad;
        bit seen;
        stall_bad = 1'b0;
        seen      = 1'b0;
        for (k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                opdata1_i = ~opdata1_i;
                opdata2_i = '0;
            end
            if (stallreq_o !== (k < lat - 1)) stall_bad = 1'b1;
            if (ready_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_latency"}, 64'(k), 64'(lat));
        check({name, "_stall"}, 64'(stall_bad), 64'd0);
        if (sb_q.size() != 0) begin
            last_exp = sb_q.pop_front();
            if (seen) check({name, "_result"}, result_o, last_exp);
        end
    endtask

    task automatic release_start(input string name);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_rel_ready"}, 64'(ready_o), 64'd0);
        check({name, "_rel_result"}, result_o, 64'd0);
    endtask

    initial begin
        bit seen_ready;
        logic [31:0] ra, rb;
        bit rs;

        tbl[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14}};
        tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD}};
        tbl[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,          32'h8000_0000}};
        tbl[3]  = '{1'b0, 32'h0000_1234,  32'd0,          64'd0};
        tbl[4]  = '{1'b0, 32'd5,          32'd9,          {32'd5,          32'd0}};
        tbl[5]  = '{1'b1, 32'd100,        32'hFFFF_FFF9,  {32'd2,          32'hFFFF_FFF2}};
        tbl[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0,          32'hFFFF_FFFF}};
        tbl[7]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'd0,          32'd1}};
        tbl[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE,  32'd14}};
        tbl[9]  = '{1'b1, 32'hFFFF_FFFD,  32'd5,          {32'hFFFF_FFFD,  32'd0}};
        tbl[10] = '{1'b0, 32'h8000_0000,  32'd3,          {32'd2,          32'h2AAA_AAAA}};

        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result_o, 64'd0);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_stall", 64'(stallreq_o), 64'd0);
        resetn = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            launch(tbl[i].sgn, tbl[i].a, tbl[i].b, nm);
            check({nm, "_table_vs_model"}, sb_q[sb_q.size()-1], tbl[i].exp);
            await_result(exp_lat(tbl[i].sgn, tbl[i].a, tbl[i].b), nm);
            check({nm, "_table"}, result_o, tbl[i].exp);
            if (i == 0) begin
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    check("hold_ready", 64'(ready_o), 64'd1);
                    check("hold_result", result_o, last_exp);
                    check("hold_stall", 64'(stallreq_o), 64'd0);
                end
            end
            release_start(nm);
        end

        for (int j = 0; j < 6; j++) begin
            string nm;
            nm = $sformatf("rnd%0d", j);
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (j % 2 == 1) ? 32'($urandom_range(1, 300)) : $urandom;
            launch(rs, ra, rb, nm);
            await_result(exp_lat(rs, ra, rb), nm);
            release_start(nm);
        end

        // Flush during iteration 10, then relaunch with start held.
        launch(1'b0, 32'd100, 32'd7, "annul");
        seen_ready = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen_ready = 1'b1;
        end
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        void'(sb_q.pop_back());
        check("annul_ready", 64'(ready_o), 64'd0);
        check("annul_result", result_o, 64'd0);
        check("annul_no_ready_seen", 64'(seen_ready), 64'd0);
        launch(1'b0, 32'd9, 32'd3, "after_annul");
        await_result(WIDTH + 1, "after_annul");
        check("after_annul_val", result_o, {32'd0, 32'd3});
        release_start("after_annul");

        // Reset mid-iteration aborts with all outputs cleared.
        launch(1'b1, 32'hFFFF_FF9C, 32'd7, "rst_mid");
        repeat (6) @(posedge clk);
        #1;
        resetn  = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        void'(sb_q.pop_back());
        check("rst_mid_ready", 64'(ready_o), 64'd0);
        check("rst_mid_result", result_o, 64'd0);
        check("rst_mid_stall", 64'(stallreq_o), 64'd0);
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_idle_ready", 64'(ready_o), 64'd0);
        launch(1'b0, 32'd100, 32'd7, "post_rst");
        await_result(WIDTH + 1, "post_rst");
        release_start("post_rst");

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
